// File: rtl/dec16_rr_arbiter_if.sv
// Request/grant bundle between requesters and the dec16 round-robin arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface dec16_rr_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic        sel_en;
  logic [15:0] gnt;
  logic        busy;
  logic        timeout;

  modport master (
    output req, done,
    input  sel, sel_en, gnt, busy, timeout
  );

  modport slave (
    input  req, done,
    output sel, sel_en, gnt, busy, timeout
  );
endinterface

// File: rtl/dec16_rr_arbiter.sv
// Round-robin arbiter driving the select/enable of a 4-to-16 decoder.
// Break-before-make grants with an optional per-owner hold limit.
module dec16_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input logic               clk,
  input logic               rst_n,
  dec16_rr_arbiter_if.slave bus
);

  localparam int HW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [3:0]      ptr;
  logic [HW-1:0]   hcnt;
  logic [3:0]      winner;
  logic            hold_hit;
  logic            release_now;

  // Scan starting at ptr and wrapping 15 -> 0; first set bit wins.
  always_comb begin
    logic       found;
    logic [3:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    hold_hit    = (HOLD_MAX != 0) && (hcnt == HW'(HOLD_MAX));
    release_now = bus.done || !bus.req[bus.sel] || hold_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hcnt        <= '0;
      bus.sel     <= '0;
      bus.sel_en  <= 1'b0;
      bus.gnt     <= '0;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state      <= GRANT;
            bus.sel    <= winner;
            bus.sel_en <= 1'b1;
            bus.gnt    <= 16'b1 << winner;
            bus.busy   <= 1'b1;
            hcnt       <= HW'(1);
          end
        end
        GRANT: begin
          if (release_now) begin
            state       <= IDLE;
            bus.sel_en  <= 1'b0;
            bus.gnt     <= '0;
            bus.busy    <= 1'b0;
            ptr         <= bus.sel + 4'd1;
            // Pulse only when the hold limit is the sole reason for release.
            bus.timeout <= hold_hit && !bus.done && bus.req[bus.sel];
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec16_rr_arbiter.sv
// Self-checking bench for dec16_rr_arbiter: vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_dec16_rr_arbiter;

  localparam int HM = 8;

  logic clk;
  logic rst_n;
  dec16_rr_arbiter_if bus ();

  dec16_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner index (-1 when idle), scan start, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_last  = 0;
  bit m_to    = 0;

  function automatic void m_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0; m_to = 0;
  endfunction

  function automatic void m_step(logic [15:0] r, logic d);
    bit lim;
    m_to = 0;
    if (m_owner < 0) begin
      if (r != 0) begin
        for (int i = 0; i < 16; i++) begin
          int c;
          c = (m_ptr + i) % 16;
          if (r[c]) begin
            m_owner = c; m_last = c; m_hold = 1;
            break;
          end
        end
      end
    end else begin
      lim = (HM != 0) && (m_hold == HM);
      if (d || !r[m_owner] || lim) begin
        m_to    = lim && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 16;
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic [3:0] esel, logic een,
                         logic [15:0] egnt, logic eto);
    chk({tag, ".sel"},     32'(bus.sel),     32'(esel));
    chk({tag, ".sel_en"},  32'(bus.sel_en),  32'(een));
    chk({tag, ".gnt"},     32'(bus.gnt),     32'(egnt));
    chk({tag, ".busy"},    32'(bus.busy),    32'(een));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(eto));
  endtask

  // One clock: model samples the same inputs as the DUT, then settle.
  task automatic step();
    @(posedge clk);
    m_step(bus.req, bus.done);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req  = 16'hFFFF;
    bus.done = 1'b0;
    m_reset();
    repeat (2) begin
      @(posedge clk); #1;
      chk_all("reset_hold", 4'd0, 1'b0, 16'h0000, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = '0;
    #1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic        en;
    logic [15:0] gnt;
    logic        to;
  } vec_t;

  vec_t tbl [20];

  initial begin
    rst_n    = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;

    tbl[0]  = '{16'h0010, 1'b0, 4'd4,  1'b1, 16'h0010, 1'b0};
    tbl[1]  = '{16'h0010, 1'b0, 4'd4,  1'b1, 16'h0010, 1'b0};
    tbl[2]  = '{16'h0010, 1'b0, 4'd4,  1'b1, 16'h0010, 1'b0};
    tbl[3]  = '{16'h0010, 1'b1, 4'd4,  1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{16'h0010, 1'b0, 4'd4,  1'b1, 16'h0010, 1'b0};
    tbl[5]  = '{16'h0010, 1'b1, 4'd4,  1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{16'h0000, 1'b0, 4'd4,  1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{16'h8000, 1'b0, 4'd15, 1'b1, 16'h8000, 1'b0};
    tbl[8]  = '{16'h8001, 1'b1, 4'd15, 1'b0, 16'h0000, 1'b0};
    tbl[9]  = '{16'h8001, 1'b0, 4'd0,  1'b1, 16'h0001, 1'b0};
    tbl[10] = '{16'h8001, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0};
    tbl[11] = '{16'h8001, 1'b0, 4'd15, 1'b1, 16'h8000, 1'b0};
    tbl[12] = '{16'h8001, 1'b1, 4'd15, 1'b0, 16'h0000, 1'b0};
    tbl[13] = '{16'h0000, 1'b0, 4'd15, 1'b0, 16'h0000, 1'b0};
    tbl[14] = '{16'h0100, 1'b0, 4'd8,  1'b1, 16'h0100, 1'b0};
    tbl[15] = '{16'h0000, 1'b0, 4'd8,  1'b0, 16'h0000, 1'b0};
    tbl[16] = '{16'h0600, 1'b0, 4'd9,  1'b1, 16'h0200, 1'b0};
    tbl[17] = '{16'h0600, 1'b1, 4'd9,  1'b0, 16'h0000, 1'b0};
    tbl[18] = '{16'h0600, 1'b0, 4'd10, 1'b1, 16'h0400, 1'b0};
    tbl[19] = '{16'h0000, 1'b0, 4'd10, 1'b0, 16'h0000, 1'b0};

    do_reset();

    for (int i = 0; i < 20; i++) begin
      bus.req  = tbl[i].req;
      bus.done = tbl[i].done;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].sel, tbl[i].en, tbl[i].gnt, tbl[i].to);
    end

    // Hold limit: ptr=11 so 0x0006 goes to 1 first, then 2.
    bus.req  = 16'h0006;
    bus.done = 1'b0;
    for (int c = 1; c <= HM; c++) begin
      step();
      chk_all($sformatf("hold1_c%0d", c), 4'd1, 1'b1, 16'h0002, 1'b0);
    end
    step();
    chk_all("timeout_pulse", 4'd1, 1'b0, 16'h0000, 1'b1);
    step();
    chk_all("after_timeout", 4'd2, 1'b1, 16'h0004, 1'b0);
    for (int c = 2; c <= HM; c++) begin
      step();
      chk_all($sformatf("hold2_c%0d", c), 4'd2, 1'b1, 16'h0004, 1'b0);
    end
    bus.done = 1'b1;
    step();
    chk_all("done_at_limit", 4'd2, 1'b0, 16'h0000, 1'b0);

    // Asynchronous reset in the middle of a grant to 9.
    bus.done = 1'b0;
    bus.req  = 16'h0200;
    step();
    chk_all("grant9", 4'd9, 1'b1, 16'h0200, 1'b0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_all("async_reset", 4'd0, 1'b0, 16'h0000, 1'b0);
    bus.req = 16'hFFFF;
    repeat (2) begin
      @(posedge clk); #1;
      chk_all("reset_mid", 4'd0, 1'b0, 16'h0000, 1'b0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 16'h0201;
    step();
    chk_all("post_reset_grant", 4'd0, 1'b1, 16'h0001, 1'b0);

    // Full rotation with done held high throughout.
    do_reset();
    bus.req  = 16'hFFFF;
    bus.done = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      step();
      chk_all($sformatf("rot%0d_g", i), 4'(i % 16), 1'b1, 16'h1 << (i % 16), 1'b0);
      step();
      chk_all($sformatf("rot%0d_i", i), 4'(i % 16), 1'b0, 16'h0000, 1'b0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] r;
      int unsigned k;
      k = $urandom_range(0, 9);
      r = 16'($urandom);
      if (k == 0)      r = '0;
      else if (k < 4)  r = r & 16'($urandom) & 16'($urandom);
      bus.req  = r;
      bus.done = ($urandom_range(0, 4) == 0);
      step();
      chk_all("rnd",
              4'((m_owner >= 0) ? m_owner : m_last),
              (m_owner >= 0),
              (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0000,
              m_to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
